// File: rtl/rx_line_sched_pkg.sv
// Shared definitions for the RX line scheduler, frame memory and display path.
package rx_line_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      FILL,
      DONE
   } state_t;

   localparam logic [15:0] LINE_WORDS_DEF  = 16'h0050;
   localparam logic [15:0] FRAME_WORDS_DEF = 16'h9600;
   localparam logic [19:0] WD_LIMIT_DEF    = 20'h23500;

   function automatic logic [9:0] sat_inc10(input logic [9:0] v);
      return (v == 10'h3FF) ? v : v + 10'd1;
   endfunction

endpackage

// File: rtl/rx_line_sched_wd.sv
// Link watchdog: counts idle SPI cycles, saturates at LIMIT, flags the last one.
module rx_link_wd #(
   parameter logic [19:0] LIMIT = 20'h23500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        enable,
   output logic [19:0] count,
   output logic        timeout
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && count != LIMIT)
         count <= count + 20'd1;
   end

   assign timeout = enable && !clear && (count == LIMIT - 20'd1);

endmodule

// File: rtl/rx_line_sched.sv
// Places received RF line payloads into frame memory and zero-fills lost lines.
module rx_line_sched
   import rx_line_sched_pkg::*;
#(
   parameter logic [15:0] LINE_WORDS  = LINE_WORDS_DEF,
   parameter logic [15:0] FRAME_WORDS = FRAME_WORDS_DEF,
   parameter logic [19:0] WD_LIMIT    = WD_LIMIT_DEF
) (
   input  logic        Cclk,
   input  logic        rstn,
   input  logic        FrameSync0,
   input  logic        FrameSync1,
   input  logic [15:0] RxAdd,
   input  logic        RxAddValid,
   input  logic [11:0] RxData,
   input  logic        RxValid,
   input  logic        CS_n,
   output logic        WrEn,
   output logic [15:0] WrAdd,
   output logic [11:0] WrData,
   output logic        ZeroPadOn,
   output logic        FrameSel,
   output logic        FrameDone,
   output logic [9:0]  LostLines
);

   state_t      state, state_n;
   logic [15:0] ptr, ptr_n;
   logic [15:0] next_line, nl_n;
   logic [15:0] fill_cnt, fcnt_n;
   logic [9:0]  lost_n;
   logic        fsel_n;
   logic        wd_clr, wd_en, wd_to;
   logic [19:0] wd_count;
   logic        sync, add_take, wr_req, wr_fill, wr_ok, done_req;
   logic [15:0] wr_addr;
   logic [11:0] wr_word;

   assign sync = FrameSync0 | FrameSync1;

   rx_link_wd #(.LIMIT(WD_LIMIT)) u_wd (
      .clk     (Cclk),
      .rst_n   (rstn),
      .clear   (wd_clr),
      .enable  (wd_en),
      .count   (wd_count),
      .timeout (wd_to)
   );

   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      nl_n     = next_line;
      fcnt_n   = fill_cnt;
      lost_n   = LostLines;
      fsel_n   = FrameSel;
      wd_clr   = ~CS_n;
      wd_en    = (state == RECV) && CS_n;
      add_take = 1'b0;
      wr_req   = 1'b0;
      wr_fill  = 1'b0;
      wr_ok    = 1'b0;
      wr_addr  = ptr;
      wr_word  = RxData;
      done_req = 1'b0;
      if (sync) begin
         state_n = RECV;
         ptr_n   = '0;
         nl_n    = LINE_WORDS;
         lost_n  = '0;
         fsel_n  = ~FrameSync0;
         wd_clr  = 1'b1;
      end else begin
         unique case (state)
            RECV: begin
               if (RxAddValid)
                  add_take = 1'b1;
               else if (RxValid)
                  wr_req = 1'b1;
               else if (wd_to) begin
                  if (next_line >= FRAME_WORDS) begin
                     state_n  = DONE;
                     done_req = 1'b1;
                  end else begin
                     state_n = FILL;
                     ptr_n   = next_line;
                     fcnt_n  = '0;
                  end
               end
            end
            FILL: begin
               if (RxAddValid) begin
                  add_take = 1'b1;
                  state_n  = RECV;
               end else begin
                  wr_req  = 1'b1;
                  wr_fill = 1'b1;
                  wr_word = '0;
                  fcnt_n  = fill_cnt + 16'd1;
                  if (fill_cnt == LINE_WORDS - 16'd1) begin
                     state_n = RECV;
                     nl_n    = next_line + LINE_WORDS;
                     lost_n  = sat_inc10(LostLines);
                     wd_clr  = 1'b1;
                  end
               end
            end
            default: ;
         endcase
         if (add_take) begin
            ptr_n   = RxAdd;
            nl_n    = RxAdd + LINE_WORDS;
            wd_clr  = 1'b1;
            wr_addr = RxAdd;
            wr_req  = RxValid;
         end
         // out-of-frame addresses are never written
         wr_ok = wr_req && (wr_addr < FRAME_WORDS);
         if (wr_ok) begin
            ptr_n = wr_addr + 16'd1;
            if (wr_addr + 16'd1 == FRAME_WORDS) begin
               state_n  = DONE;
               done_req = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Cclk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         ptr       <= '0;
         next_line <= LINE_WORDS;
         fill_cnt  <= '0;
         LostLines <= '0;
         FrameSel  <= 1'b0;
         WrEn      <= 1'b0;
         WrAdd     <= '0;
         WrData    <= '0;
         ZeroPadOn <= 1'b0;
         FrameDone <= 1'b0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         next_line <= nl_n;
         fill_cnt  <= fcnt_n;
         LostLines <= lost_n;
         FrameSel  <= fsel_n;
         WrEn      <= wr_ok;
         ZeroPadOn <= wr_ok && wr_fill;
         FrameDone <= done_req;
         if (wr_ok) begin
            WrAdd  <= wr_addr;
            WrData <= wr_word;
         end
      end
   end

endmodule

// File: tb/tb_rx_line_sched.sv
// Directed bench for rx_line_sched with a shortened watchdog limit.
module tb_rx_line_sched;

   logic        Cclk = 1'b0;
   logic        rstn;
   logic        FrameSync0, FrameSync1;
   logic [15:0] RxAdd;
   logic        RxAddValid;
   logic [11:0] RxData;
   logic        RxValid;
   logic        CS_n;
   logic        WrEn;
   logic [15:0] WrAdd;
   logic [11:0] WrData;
   logic        ZeroPadOn, FrameSel, FrameDone;
   logic [9:0]  LostLines;

   int vec  = 0;
   int miss = 0;

   rx_line_sched #(
      .LINE_WORDS  (16'h0050),
      .FRAME_WORDS (16'h9600),
      .WD_LIMIT    (20'd40)
   ) dut (
      .Cclk       (Cclk),
      .rstn       (rstn),
      .FrameSync0 (FrameSync0),
      .FrameSync1 (FrameSync1),
      .RxAdd      (RxAdd),
      .RxAddValid (RxAddValid),
      .RxData     (RxData),
      .RxValid    (RxValid),
      .CS_n       (CS_n),
      .WrEn       (WrEn),
      .WrAdd      (WrAdd),
      .WrData     (WrData),
      .ZeroPadOn  (ZeroPadOn),
      .FrameSel   (FrameSel),
      .FrameDone  (FrameDone),
      .LostLines  (LostLines)
   );

   always #5 Cclk = ~Cclk;

   task automatic tick();
      @(posedge Cclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic quiet();
      FrameSync0 = 1'b0;
      FrameSync1 = 1'b0;
      RxAddValid = 1'b0;
      RxValid    = 1'b0;
   endtask

   task automatic wait_wr(output int n);
      n = 0;
      for (int k = 1; k <= 300; k++) begin
         tick();
         if (WrEn) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic start_line0(input logic s1);
      quiet();
      FrameSync0 = ~s1;
      FrameSync1 = s1;
      tick();
      quiet();
      RxAddValid = 1'b1;
      RxAdd      = 16'h0000;
      CS_n       = 1'b1;
      tick();
      quiet();
   endtask

   int n;
   int done_cnt;

   initial begin
      rstn  = 1'b0;
      quiet();
      RxAdd  = '0;
      RxData = '0;
      CS_n   = 1'b1;
      repeat (3) tick();
      chk("rst_wren", WrEn, 0);
      chk("rst_wradd", WrAdd, 0);
      chk("rst_wrdata", WrData, 0);
      chk("rst_zpad", ZeroPadOn, 0);
      chk("rst_fsel", FrameSel, 0);
      chk("rst_done", FrameDone, 0);
      chk("rst_lost", LostLines, 0);
      rstn = 1'b1;
      tick();

      // idle ignores strobes
      RxValid = 1'b1; RxAddValid = 1'b1; RxAdd = 16'h0005;
      tick();
      chk("idle_nowr", WrEn, 0);

      // frame sync drops its own RxValid
      quiet();
      FrameSync1 = 1'b1; RxValid = 1'b1; RxData = 12'h777;
      tick();
      chk("sync_nowr", WrEn, 0);
      chk("sync1_fsel", FrameSel, 1);
      quiet();
      CS_n = 1'b0;
      RxAddValid = 1'b1; RxAdd = 16'h00A0;
      tick();
      chk("add_nowr", WrEn, 0);
      quiet();
      for (int i = 0; i < 3; i++) begin
         RxValid = 1'b1;
         RxData  = 12'h111 * (i + 1);
         tick();
         chk("rx_wren", WrEn, 1);
         chk("rx_wradd", WrAdd, 32'h00A0 + i);
         chk("rx_wrdata", WrData, 32'h111 * (i + 1));
         chk("rx_zpad", ZeroPadOn, 0);
      end
      quiet();
      tick();
      chk("rx_after", WrEn, 0);

      // lost line zero-filled after watchdog timeout
      start_line0(1'b0);
      chk("s0_fsel", FrameSel, 0);
      wait_wr(n);
      chk("wd_latency", n, 41);
      for (int i = 0; i < 80; i++) begin
         if (i > 0) tick();
         chk("fill_wren", WrEn, 1);
         chk("fill_zpad", ZeroPadOn, 1);
         chk("fill_add", WrAdd, 32'h0050 + i);
         chk("fill_data", WrData, 0);
      end
      tick();
      chk("fill_end_wren", WrEn, 0);
      chk("fill_end_zpad", ZeroPadOn, 0);
      chk("fill_lost", LostLines, 1);
      CS_n = 1'b0;
      tick();

      // header arriving mid-fill aborts it
      start_line0(1'b0);
      wait_wr(n);
      chk("ab_latency", n, 41);
      chk("ab_first", WrAdd, 16'h0050);
      for (int i = 1; i < 10; i++) tick();
      chk("ab_last", WrAdd, 16'h0059);
      chk("ab_last_zp", ZeroPadOn, 1);
      RxAddValid = 1'b1; RxAdd = 16'h0140; CS_n = 1'b0;
      tick();
      chk("ab_nowr", WrEn, 0);
      chk("ab_nozp", ZeroPadOn, 0);
      quiet();
      RxValid = 1'b1; RxData = 12'hABC;
      tick();
      chk("ab_wren", WrEn, 1);
      chk("ab_wradd", WrAdd, 16'h0140);
      chk("ab_wrdata", WrData, 12'hABC);
      chk("ab_lost", LostLines, 0);

      // last line of the frame
      quiet();
      RxAddValid = 1'b1; RxAdd = 16'h95B0;
      tick();
      quiet();
      done_cnt = 0;
      for (int i = 0; i < 80; i++) begin
         RxValid = 1'b1;
         RxData  = 12'h200 + 12'(i);
         tick();
         chk("end_wren", WrEn, 1);
         chk("end_wradd", WrAdd, 32'h95B0 + i);
         chk("end_done", FrameDone, (i == 79) ? 1 : 0);
         done_cnt += int'(FrameDone);
      end
      chk("end_lastadd", WrAdd, 16'h95FF);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_nowr", WrEn, 0);
         done_cnt += int'(FrameDone);
      end
      chk("done_once", done_cnt, 1);
      quiet();

      // simultaneous syncs during a fill
      start_line0(1'b1);
      wait_wr(n);
      chk("tie_first", WrAdd, 16'h0050);
      for (int i = 1; i < 80; i++) tick();
      tick();
      chk("tie_lost1", LostLines, 1);
      wait_wr(n);
      chk("tie_fill2", WrAdd, 16'h00A0);
      chk("tie_fill2zp", ZeroPadOn, 1);
      tick();
      FrameSync0 = 1'b1; FrameSync1 = 1'b1;
      tick();
      chk("tie_nowr", WrEn, 0);
      chk("tie_fsel", FrameSel, 0);
      chk("tie_lost0", LostLines, 0);
      quiet();
      CS_n = 1'b0;
      RxValid = 1'b1; RxData = 12'h321;
      tick();
      chk("tie_recv_wr", WrEn, 1);
      chk("tie_recv_add", WrAdd, 0);
      chk("tie_recv_zp", ZeroPadOn, 0);
      quiet();

      // reset in the middle of a fill
      start_line0(1'b1);
      wait_wr(n);
      for (int i = 1; i < 40; i++) tick();
      chk("mid_add40", WrAdd, 16'h0077);
      #2 rstn = 1'b0;
      #1;
      chk("mid_wren", WrEn, 0);
      chk("mid_wradd", WrAdd, 0);
      chk("mid_zpad", ZeroPadOn, 0);
      chk("mid_fsel", FrameSel, 0);
      tick();
      tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      CS_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         RxValid = 1'b1; RxAddValid = 1'b1; RxAdd = 16'h0010;
         tick();
         chk("post_rst_nowr", WrEn, 0);
      end
      quiet();
      FrameSync1 = 1'b1;
      tick();
      quiet();
      RxValid = 1'b1; RxData = 12'h5A5;
      tick();
      chk("resync_wr", WrEn, 1);
      chk("resync_add", WrAdd, 0);
      quiet();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
